// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame decoder.
package spi_frame_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StRw,
      StDummy,
      StData,
      StCommit
   } state_e;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/spi_frame_decoder_if.sv
// SPI pins plus decoded access outputs of spi_frame_decoder.
// master: drives the SPI pins; slave: the decoder itself.
interface spi_frame_decoder_if #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned N_TARGETS = 2
);

   logic                 sclk;
   logic                 ssn;
   logic                 mosi;
   logic [ADDR_W-1:0]    addr;
   logic [DATA_W-1:0]    wdata;
   logic [N_TARGETS-1:0] tgt_sel;
   logic                 rd_en;
   logic                 wr_en;
   logic                 tx_req;
   logic                 frame_err;
   logic                 busy;

   modport master (
      output sclk, ssn, mosi,
      input  addr, wdata, tgt_sel, rd_en, wr_en, tx_req, frame_err, busy
   );

   modport slave (
      input  sclk, ssn, mosi,
      output addr, wdata, tgt_sel, rd_en, wr_en, tx_req, frame_err, busy
   );

endinterface

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for one asynchronous pin, with rise/fall detect on the
// synchronised value.
module spi_pin_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic q,
   output logic rise,
   output logic fall
);

   // [0],[1] synchronise; [2] holds the previous synchronised value
   logic [2:0] sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], din};
      end
   end

   assign q    = sync_q[1];
   assign rise = sync_q[1] & ~sync_q[2];
   assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_frame_decoder.sv
// SPI slave frame decoder: address, RW, dummy turnaround, then data words.
// Define SPI_FRAME_BURST_EN to allow multi-word bursts with address increment.
module spi_frame_decoder
   import spi_frame_pkg::*;
#(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned DUMMY_BITS = 7,
   parameter int unsigned N_TARGETS  = 2
) (
   input logic                clk,
   input logic                reset,
   spi_frame_decoder_if.slave bus
);

   localparam int unsigned TGT_W   = $clog2(N_TARGETS);
   localparam int unsigned SHIFT_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int unsigned MAX_CNT = (SHIFT_W > DUMMY_BITS) ? SHIFT_W : DUMMY_BITS;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_BITS - 1);
   localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);

   function automatic logic [N_TARGETS-1:0] decode_tgt(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] idx;
      idx = a >> (ADDR_W - TGT_W);
      return N_TARGETS'(1) << idx;
   endfunction

   logic sclk_rise, ssn_s, ssn_rise, ssn_fall, mosi_s;
   logic unused_sclk_q, unused_sclk_fall, unused_mosi_rise, unused_mosi_fall;

   spi_pin_sync u_sync_sclk (
      .clk   (clk),
      .reset (reset),
      .din   (bus.sclk),
      .q     (unused_sclk_q),
      .rise  (sclk_rise),
      .fall  (unused_sclk_fall)
   );

   spi_pin_sync u_sync_ssn (
      .clk   (clk),
      .reset (reset),
      .din   (bus.ssn),
      .q     (ssn_s),
      .rise  (ssn_rise),
      .fall  (ssn_fall)
   );

   spi_pin_sync u_sync_mosi (
      .clk   (clk),
      .reset (reset),
      .din   (bus.mosi),
      .q     (mosi_s),
      .rise  (unused_mosi_rise),
      .fall  (unused_mosi_fall)
   );

   state_e               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [SHIFT_W-1:0]   shreg_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [N_TARGETS-1:0] tgt_q;
   logic                 rw_q;
   logic                 rd_en_q, wr_en_q, tx_req_q, frame_err_q;
   logic                 ssn_pend_q, rd_pend_q, inc_pend_q;

   logic                 sample, rise_now;
   logic [ADDR_W-1:0]    new_addr, addr_inc;
   logic [SHIFT_W-1:0]   shreg_next;

   // A sample in the same cycle as the ssn rise still counts; the rise is deferred.
   assign sample     = sclk_rise & ~(ssn_s & ~ssn_rise);
   assign rise_now   = ssn_rise | ssn_pend_q;
   assign shreg_next = {shreg_q[SHIFT_W-2:0], mosi_s};
   assign new_addr   = {shreg_q[ADDR_W-2:0], mosi_s};
   assign addr_inc   = addr_q + ADDR_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         shreg_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         tgt_q       <= '0;
         rw_q        <= RW_WRITE;
         rd_en_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         tx_req_q    <= 1'b0;
         frame_err_q <= 1'b0;
         ssn_pend_q  <= 1'b0;
         rd_pend_q   <= 1'b0;
         inc_pend_q  <= 1'b0;
      end else begin
         rd_en_q     <= rd_pend_q;
         wr_en_q     <= 1'b0;
         tx_req_q    <= 1'b0;
         frame_err_q <= 1'b0;
         rd_pend_q   <= 1'b0;
         inc_pend_q  <= 1'b0;
         // Write bursts step the address one cycle after the wr_en pulse
         if (inc_pend_q) begin
            addr_q <= addr_inc;
            tgt_q  <= decode_tgt(addr_inc);
         end
         if (sample && ssn_rise) begin
            ssn_pend_q <= 1'b1;
         end

         unique case (state_q)
            StIdle: begin
               ssn_pend_q <= 1'b0;
               if (ssn_fall) begin
                  state_q <= StAddr;
                  cnt_q   <= '0;
                  shreg_q <= '0;
               end
            end
            StAddr: begin
               if (sample) begin
                  shreg_q <= shreg_next;
                  if (cnt_q == ADDR_LAST) begin
                     cnt_q   <= '0;
                     addr_q  <= new_addr;
                     tgt_q   <= decode_tgt(new_addr);
                     state_q <= StRw;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end else if (rise_now) begin
                  state_q     <= StIdle;
                  frame_err_q <= 1'b1;
                  ssn_pend_q  <= 1'b0;
               end
            end
            StRw: begin
               if (sample) begin
                  rw_q    <= mosi_s;
                  rd_en_q <= (mosi_s == RW_READ);
                  state_q <= StDummy;
               end else if (rise_now) begin
                  state_q     <= StIdle;
                  frame_err_q <= 1'b1;
                  ssn_pend_q  <= 1'b0;
               end
            end
            StDummy: begin
               if (sample) begin
                  if (cnt_q == DUMMY_LAST) begin
                     cnt_q    <= '0;
                     shreg_q  <= '0;
                     tx_req_q <= (rw_q == RW_READ);
                     state_q  <= StData;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end else if (rise_now) begin
                  state_q     <= StIdle;
                  frame_err_q <= 1'b1;
                  ssn_pend_q  <= 1'b0;
               end
            end
            StData: begin
               if (sample) begin
                  shreg_q <= shreg_next;
                  if (cnt_q == DATA_LAST) begin
                     cnt_q   <= '0;
                     state_q <= StCommit;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end else if (rise_now) begin
                  // Ending on a word boundary is a clean close; a partial word is dropped
                  state_q     <= StIdle;
                  frame_err_q <= (cnt_q != '0);
                  ssn_pend_q  <= 1'b0;
               end
            end
            StCommit: begin
               if (rw_q == RW_WRITE) begin
                  wdata_q <= shreg_q[DATA_W-1:0];
                  wr_en_q <= 1'b1;
               end
`ifdef SPI_FRAME_BURST_EN
               if (rw_q == RW_WRITE) begin
                  inc_pend_q <= 1'b1;
               end else begin
                  addr_q    <= addr_inc;
                  tgt_q     <= decode_tgt(addr_inc);
                  tx_req_q  <= 1'b1;
                  rd_pend_q <= 1'b1;
               end
               state_q <= StData;
`else
               // Single-word build: rest of the frame is ignored until ssn rises
               state_q    <= StIdle;
               ssn_pend_q <= 1'b0;
`endif
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.addr      = addr_q;
   assign bus.wdata     = wdata_q;
   assign bus.tgt_sel   = tgt_q;
   assign bus.rd_en     = rd_en_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.tx_req    = tx_req_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = (state_q != StIdle);

endmodule
